// File: rtl/thresh_load_pkg.sv
// thresh_load_pkg
//   Shared definitions for the threshold-table load sequencer:
//   - tl_state_e : sequencer FSM states
//   - bit positions of the fields inside the software register word
//   Optional feature macro used by the importing files: THRESH_LOAD_SWEEP_EN
//   (enables the broadcast sweep of the whole table).
package thresh_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_DONE   = 2'd3
  } tl_state_e;

  // Field positions in cfg_word
  localparam int LOAD_BIT  = 31;
  localparam int BCAST_BIT = 30;
  localparam int CH_LSB    = 16;
  localparam int TH_LSB    = 0;

endpackage

// File: rtl/thresh_load_capture.sv
// thresh_load_capture
//   Input stage of the sequencer: registers the software register word,
//   arms itself once the load bit has been seen low, detects the rising edge
//   of the load bit and latches the channel / threshold / broadcast fields
//   when the sequencer can accept a new load.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_cfg_word     : raw register word
//   i_accept       : sequencer is idle and will take an edge this cycle
//   o_start        : registered one-cycle pulse, a load was accepted
//   o_ignored      : combinational, an edge was seen but not accepted
//   o_bcast        : latched broadcast bit
//   o_ch, o_th     : latched channel and threshold fields
module thresh_load_capture
  import thresh_load_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int TH_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [31:0]     i_cfg_word,
  input  logic            i_accept,
  output logic            o_start,
  output logic            o_ignored,
  output logic            o_bcast,
  output logic [CH_W-1:0] o_ch,
  output logic [TH_W-1:0] o_th
);

  logic [31:0]     r_cfg_q;
  logic            r_load_d;
  logic            r_sampled;
  logic            r_armed;
  logic            r_start;
  logic            r_bcast;
  logic [CH_W-1:0] r_ch;
  logic [TH_W-1:0] r_th;

  logic            w_edge;
  logic            w_take;
  logic            w_unused_cfg;

  assign w_edge = r_armed & r_cfg_q[LOAD_BIT] & ~r_load_d;
  assign w_take = w_edge & i_accept;
  // Reserved bits of the register word are carried but not interpreted.
  assign w_unused_cfg = ^r_cfg_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg_q   <= '0;
      r_load_d  <= 1'b0;
      r_sampled <= 1'b0;
      r_armed   <= 1'b0;
      r_start   <= 1'b0;
      r_bcast   <= 1'b0;
      r_ch      <= '0;
      r_th      <= '0;
    end else begin
      r_cfg_q   <= i_cfg_word;
      r_load_d  <= r_cfg_q[LOAD_BIT];
      r_sampled <= 1'b1;
      // Arm only on a genuinely sampled low load bit; the reset value of
      // r_cfg_q must not count, so a bit held high through reset never fires.
      if (r_sampled && !r_cfg_q[LOAD_BIT]) begin
        r_armed <= 1'b1;
      end
      r_start <= w_take;
      if (w_take) begin
        r_bcast <= r_cfg_q[BCAST_BIT];
        r_ch    <= r_cfg_q[CH_LSB +: CH_W];
        r_th    <= r_cfg_q[TH_LSB +: TH_W];
      end
    end
  end

  assign o_start   = r_start;
  assign o_ignored = w_edge & ~i_accept;
  assign o_bcast   = r_bcast;
  assign o_ch      = r_ch;
  assign o_th      = r_th;

endmodule

// File: rtl/thresh_load_sequencer.sv
// thresh_load_sequencer
//   Turns a rising edge of the load bit in the software register word into
//   either one write to the threshold RAM or (with THRESH_LOAD_SWEEP_EN
//   defined) a broadcast sweep writing every channel. Reports busy, a done
//   pulse, a sticky overrun flag and a completed-load counter.
//
//   Write handshake: a transfer happens at a rising clock edge where
//   wr_en & wr_ready. While wr_en is high, wr_addr/wr_data hold until the
//   transfer; wr_en never drops without a transfer.
//
//   Optional feature macro: THRESH_LOAD_SWEEP_EN. Undefined, the broadcast
//   bit is ignored and every load is a single write.
//
// Ports
//   user_clk, user_rst_n : clock, asynchronous active-low reset
//   cfg_word             : register word ([31] load, [30] broadcast,
//                          [16+CH_W-1:16] channel, [TH_W-1:0] threshold)
//   wr_en/wr_ready       : RAM write request / accept
//   wr_addr, wr_data     : RAM write address / threshold value
//   busy, done, overrun  : status (done is a one-cycle pulse)
//   load_count           : completed loads, wraps
//   dbg_state            : current FSM state
module thresh_load_sequencer
  import thresh_load_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int TH_W = 16
) (
  input  logic            user_clk,
  input  logic            user_rst_n,
  input  logic [31:0]     cfg_word,
  output logic            wr_en,
  input  logic            wr_ready,
  output logic [CH_W-1:0] wr_addr,
  output logic [TH_W-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic            overrun,
  output logic [15:0]     load_count,
  output tl_state_e       dbg_state
);

  localparam logic [CH_W-1:0] LAST_ADDR = {CH_W{1'b1}};
  localparam logic [CH_W-1:0] ADDR_ONE  = {{(CH_W-1){1'b0}}, 1'b1};

  tl_state_e       r_state;
  tl_state_e       w_state_nxt;

  logic            r_wr_en;
  logic [CH_W-1:0] r_wr_addr;
  logic [TH_W-1:0] r_wr_data;
  logic            r_busy;
  logic            r_done;
  logic            r_overrun;
  logic [15:0]     r_load_count;

  logic            w_wr_en_nxt;
  logic [CH_W-1:0] w_wr_addr_nxt;
  logic [TH_W-1:0] w_wr_data_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_overrun_nxt;
  logic [15:0]     w_load_count_nxt;

  logic            w_start;
  logic            w_ignored;
  logic            w_bcast;
  logic [CH_W-1:0] w_ch;
  logic [TH_W-1:0] w_th;
  logic            w_accept;
  logic            w_xfer;

  // A start pulse already in flight means the FSM is about to leave IDLE.
  assign w_accept = (r_state == ST_IDLE) & ~w_start;
  assign w_xfer   = r_wr_en & wr_ready;

  thresh_load_capture #(
    .CH_W (CH_W),
    .TH_W (TH_W)
  ) u_capture (
    .i_clk      (user_clk),
    .i_rst_n    (user_rst_n),
    .i_cfg_word (cfg_word),
    .i_accept   (w_accept),
    .o_start    (w_start),
    .o_ignored  (w_ignored),
    .o_bcast    (w_bcast),
    .o_ch       (w_ch),
    .o_th       (w_th)
  );

`ifndef THRESH_LOAD_SWEEP_EN
  logic w_unused_bcast;
  assign w_unused_bcast = w_bcast;
`endif

  // State register
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
`ifdef THRESH_LOAD_SWEEP_EN
          w_state_nxt = w_bcast ? ST_SWEEP : ST_SINGLE;
`else
          w_state_nxt = ST_SINGLE;
`endif
        end
      end
      ST_SINGLE: begin
        if (w_xfer) begin
          w_state_nxt = ST_DONE;
        end
      end
`ifdef THRESH_LOAD_SWEEP_EN
      ST_SWEEP: begin
        if (w_xfer && (r_wr_addr == LAST_ADDR)) begin
          w_state_nxt = ST_DONE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered outputs. wr_addr doubles as
  // the sweep index, so no separate sweep counter exists.
  always_comb begin
    w_wr_en_nxt      = (w_state_nxt == ST_SINGLE) || (w_state_nxt == ST_SWEEP);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_done_nxt       = (w_state_nxt == ST_DONE);
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_overrun_nxt    = r_overrun;
    w_load_count_nxt = r_load_count;

    if ((r_state == ST_IDLE) && w_start) begin
      w_wr_data_nxt = w_th;
      w_overrun_nxt = 1'b0;
`ifdef THRESH_LOAD_SWEEP_EN
      w_wr_addr_nxt = w_bcast ? '0 : w_ch;
`else
      w_wr_addr_nxt = w_ch;
`endif
    end
`ifdef THRESH_LOAD_SWEEP_EN
    else if ((r_state == ST_SWEEP) && w_xfer && (r_wr_addr != LAST_ADDR)) begin
      w_wr_addr_nxt = r_wr_addr + ADDR_ONE;
    end
`endif

    if (w_ignored) begin
      w_overrun_nxt = 1'b1;
    end

    if (r_state == ST_DONE) begin
      w_load_count_nxt = r_load_count + 16'd1;
    end
  end

  // Output registers
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_load_count <= '0;
    end else begin
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_overrun    <= w_overrun_nxt;
      r_load_count <= w_load_count_nxt;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign load_count = r_load_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_thresh_load_sequencer.sv
// Testbench for thresh_load_sequencer. Expected RAM writes come from a
// queue filled per load: one entry for a single write, NCHAN entries for a
// broadcast when THRESH_LOAD_SWEEP_EN is defined.
module tb_thresh_load_sequencer;

  localparam int CH_W  = 8;
  localparam int TH_W  = 16;
  localparam int NCHAN = 1 << CH_W;
`ifdef THRESH_LOAD_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic            user_clk;
  logic            user_rst_n;
  logic [31:0]     cfg_word;
  logic            wr_en;
  logic            wr_ready;
  logic [CH_W-1:0] wr_addr;
  logic [TH_W-1:0] wr_data;
  logic            busy;
  logic            done;
  logic            overrun;
  logic [15:0]     load_count;
  thresh_load_pkg::tl_state_e dbg_state;

  logic [CH_W+TH_W-1:0] exp_q[$];
  logic [15:0]          exp_count;
  int                   exp_done;
  int                   done_cnt;
  int                   total;
  int                   bad;

  thresh_load_sequencer #(.CH_W(CH_W), .TH_W(TH_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .cfg_word   (cfg_word),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .load_count (load_count),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // Reference model: what a load word should write into the table.
  task automatic model_push(input logic [31:0] word);
    if (SWEEP_EN && word[30]) begin
      for (int a = 0; a < NCHAN; a++) begin
        exp_q.push_back({a[CH_W-1:0], word[TH_W-1:0]});
      end
    end else begin
      exp_q.push_back({word[16 +: CH_W], word[TH_W-1:0]});
    end
  endtask

  // Load bit low for two samples, then raise it with the given fields.
  task automatic start_load(input logic [31:0] word);
    tick();
    cfg_word = word & 32'h7FFF_FFFF;
    tick();
    tick();
    model_push(word);
    cfg_word = word;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) tick();
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      if (rnd) wr_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    wr_ready = 1'b1;
    chk("idle_busy", busy, 0);
    chk("idle_queue_empty", exp_q.size(), 0);
  endtask

  task automatic finish_load(input bit rnd);
    wait_idle(4000, rnd);
    exp_count++;
    exp_done++;
    chk("load_count", load_count, exp_count);
    cfg_word[31] = 1'b0;
  endtask

  task automatic issue(input logic [31:0] word, input bit rnd);
    start_load(word);
    finish_load(rnd);
  endtask

  task automatic wait_addr(input logic [CH_W-1:0] target, input int budget, input bit rnd);
    int n;
    n = 0;
    while (!(wr_en && wr_addr == target) && n < budget) begin
      tick();
      n++;
      if (!(wr_en && wr_addr == target) && rnd) wr_ready = ($urandom_range(0, 3) != 0);
    end
    chk("reach_addr", {wr_en, wr_addr}, {1'b1, target});
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial begin : monitor
    bit                   prev_done;
    bit                   prev_stall;
    logic [CH_W+TH_W-1:0] prev_pay;
    logic [CH_W+TH_W-1:0] e;
    prev_done  = 1'b0;
    prev_stall = 1'b0;
    prev_pay   = '0;
    forever begin
      @(negedge user_clk);
      if (!user_rst_n) begin
        prev_done  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("done_one_cycle", prev_done, 0);
        end
        if (prev_stall) chk("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, prev_pay});
        if (wr_en && wr_ready) begin
          chk("xfer_expected", {wr_en, wr_ready}, {1'b1, exp_q.size() != 0});
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("xfer_payload", {wr_addr, wr_data}, e);
          end
        end
        prev_done  = done;
        prev_stall = wr_en & ~wr_ready;
        prev_pay   = {wr_addr, wr_data};
      end
    end
  end

  initial begin : main
    int          n;
    logic [31:0] w;
    total     = 0;
    bad       = 0;
    exp_count = '0;
    exp_done  = 0;
    done_cnt  = 0;

    // Reset values
    user_rst_n = 1'b0;
    cfg_word   = '0;
    wr_ready   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_state", dbg_state, thresh_load_pkg::ST_IDLE);
    user_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Single load with exact latency: word sampled at edge k
    tick();
    model_push(32'h8005_0123);
    cfg_word = 32'h8005_0123;
    tick();                                   // edge k
    tick();                                   // edge k+1
    chk("lat_k1_busy", {busy, wr_en}, 2'b00);
    tick();                                   // edge k+2
    chk("lat_k2_req", {busy, wr_en, wr_addr, wr_data}, {2'b11, 8'h05, 16'h0123});
    tick();                                   // edge k+3, transfer
    chk("lat_k3_done", {busy, wr_en, done}, 3'b101);
    tick();                                   // edge k+4
    chk("lat_k4_idle", {busy, done}, 2'b00);
    exp_count++;
    exp_done++;
    chk("single_count", load_count, exp_count);
    chk("single_queue", exp_q.size(), 0);
    cfg_word = 32'h0005_0123;

    // Broadcast with ready tied high: contiguous writes
    start_load(32'hC000_7FFF);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (wr_en) n++;
      if (!busy && n > 0) break;
    end
    chk("sweep_len", n, SWEEP_EN ? NCHAN : 1);
    finish_load(1'b0);
    chk("sweep_busy_low", busy, 0);

    // Backpressure for five cycles at address 17
    start_load(32'hC011_2222);
    wait_addr(8'd17, 1000, 1'b0);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_hold", {wr_en, wr_addr, wr_data}, {1'b1, 8'd17, 16'h2222});
    wr_ready = 1'b1;
    finish_load(1'b0);

    // Overrun: load edge while busy at address 40
    w = {1'b1, 1'b1, 6'b0, 8'd40, 16'($urandom)};
    start_load(w);
    wait_addr(8'd40, 2000, 1'b1);
    wr_ready = 1'b0;
    cfg_word[31] = 1'b0;
    tick();
    tick();
    cfg_word = 32'h80AB_CDEF;
    for (int i = 0; i < 4; i++) tick();
    chk("ovr_set", overrun, 1);
    chk("ovr_no_relatch", {wr_addr, wr_data}, {8'd40, w[15:0]});
    wr_ready = 1'b1;
    finish_load(1'b1);
    chk("ovr_sticky", overrun, 1);
    issue({1'b1, 1'b0, 6'b0, 8'($urandom), 16'($urandom)}, 1'b1);
    chk("ovr_cleared", overrun, 0);

    // Reset in the middle of a load at address 100
    start_load(32'hC064_5A5A);
    wait_addr(8'd100, 2000, 1'b1);
    user_rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", load_count, 0);
    exp_q.delete();
    exp_count = '0;
    wr_ready  = 1'b1;
    // Load bit stays high across reset release: must not trigger
    for (int i = 0; i < 3; i++) tick();
    user_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("arm_no_write", {busy, wr_en}, 2'b00);
    chk("arm_count", load_count, 0);
    issue(32'h8009_1234, 1'b0);

    // Broadcast bit with sweep disabled gives one write
    issue(32'hC003_0010, 1'b1);

    // Random loads
    for (int r = 0; r < 8; r++) begin
      w = {1'b1, ($urandom_range(0, 3) == 0), 6'($urandom), 8'($urandom), 16'($urandom)};
      issue(w, 1'b1);
    end
    for (int i = 0; i < 4; i++) tick();
    chk("done_total", done_cnt, exp_done);
    chk("final_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
